// File: rtl/sprite_pkg.sv
// Shared widths and piece encodings for the sprite compositor.
// Latency: none (types and constants only). Backpressure: none.
package sprite_pkg;
    localparam int COORD_W = 10;
    localparam int EXT_W   = 14;
    localparam int RGB_W   = 12;

    typedef enum logic [1:0] {
        PIECE_WHOLE = 2'b00,
        PIECE_LEFT  = 2'b01,
        PIECE_RIGHT = 2'b10
    } piece_e;
endpackage

// File: rtl/sprite_hit_calc.sv
// Per-channel hit test and texel address for one sprite piece.
// Latency: combinational. Backpressure: none.
module sprite_hit_calc
    import sprite_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic               en,
    input  logic [1:0]         piece,
    input  logic [COORD_W-1:0] col,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    input  logic [1:0]         scale,
    input  logic [ADDR_W-1:0]  base,
    output logic               hit,
    output logic [ADDR_W-1:0]  addr
);
    localparam int PROD_W = 2 * EXT_W;

    logic [COORD_W-1:0] half;
    logic [COORD_W-1:0] pw;
    logic [COORD_W-1:0] sx_off;
    logic [EXT_W:0]     dx_full;
    logic [EXT_W:0]     dy_full;
    logic [EXT_W-1:0]   dx;
    logic [EXT_W-1:0]   dy;
    logic [EXT_W-1:0]   ext_x;
    logic [EXT_W-1:0]   ext_y;
    logic [EXT_W-1:0]   dxs;
    logic [EXT_W-1:0]   dys;
    logic [PROD_W-1:0]  prod;

    always_comb begin
        half = w >> 1;
        pw     = w;
        sx_off = '0;
        if (piece == PIECE_LEFT) begin
            pw = half;
        end else if (piece == PIECE_RIGHT) begin
            // odd widths give the spare column to the right half
            pw     = w - half;
            sx_off = half;
        end

        dx_full = {1'b0, EXT_W'(col)} - {1'b0, EXT_W'(x)};
        dy_full = {1'b0, EXT_W'(row)} - {1'b0, EXT_W'(y)};
        dx      = dx_full[EXT_W-1:0];
        dy      = dy_full[EXT_W-1:0];
        ext_x   = EXT_W'(pw) << scale;
        ext_y   = EXT_W'(h) << scale;

        hit = en && (w != '0) && (h != '0) && !dx_full[EXT_W] && !dy_full[EXT_W]
              && (dx < ext_x) && (dy < ext_y);

        dxs  = dx >> scale;
        dys  = dy >> scale;
        prod = PROD_W'(dys) * PROD_W'(w);
        addr = base + ADDR_W'(prod) + ADDR_W'(dxs) + ADDR_W'(sx_off);
    end
endmodule

// File: rtl/sprite_compositor.sv
// N-channel sprite overlay: priority hit, one ROM fetch per pixel, colour-key over background.
// Latency: fixed 2+ROM_LAT clocks, one pixel per clock. Backpressure: none (streaming, never stalls).
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int               N_CH       = 4,
    parameter int               ADDR_W     = 18,
    parameter int               ROM_LAT    = 1,
    parameter logic [RGB_W-1:0] TRANSP_KEY = 12'h000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      pix_valid,
    input  logic [COORD_W-1:0]        col,
    input  logic [COORD_W-1:0]        row,
    input  logic [RGB_W-1:0]          bg_data,
    input  logic [N_CH-1:0]           ch_en,
    input  logic [2*N_CH-1:0]         ch_piece,
    input  logic [COORD_W*N_CH-1:0]   ch_x,
    input  logic [COORD_W*N_CH-1:0]   ch_y,
    input  logic [COORD_W*N_CH-1:0]   ch_w,
    input  logic [COORD_W*N_CH-1:0]   ch_h,
    input  logic [2*N_CH-1:0]         ch_scale,
    input  logic [ADDR_W*N_CH-1:0]    ch_base,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [RGB_W-1:0]          rom_data,
    output logic                      out_valid,
    output logic [RGB_W-1:0]          vga_data
);
    logic [N_CH-1:0]         en_q, en_d;
    logic [2*N_CH-1:0]       piece_q, piece_d;
    logic [COORD_W*N_CH-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [2*N_CH-1:0]       scale_q, scale_d;
    logic [ADDR_W*N_CH-1:0]  base_q, base_d;

    logic [ADDR_W-1:0]              rom_addr_q, rom_addr_d;
    logic [ROM_LAT:0]               dl_vld_q, dl_vld_d;
    logic [ROM_LAT:0]               dl_hit_q, dl_hit_d;
    logic [ROM_LAT:0][RGB_W-1:0]    dl_bg_q, dl_bg_d;
    logic                           out_valid_q, out_valid_d;
    logic [RGB_W-1:0]               vga_q, vga_d;

    logic [N_CH-1:0]              ch_hit;
    logic [N_CH-1:0][ADDR_W-1:0]  ch_addr;
    logic                         win_hit;
    logic [ADDR_W-1:0]            win_addr;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sprite_hit_calc #(.ADDR_W(ADDR_W)) u_hit (
            .en    (en_q[i]),
            .piece (piece_q[2*i +: 2]),
            .col   (col),
            .row   (row),
            .x     (x_q[COORD_W*i +: COORD_W]),
            .y     (y_q[COORD_W*i +: COORD_W]),
            .w     (w_q[COORD_W*i +: COORD_W]),
            .h     (h_q[COORD_W*i +: COORD_W]),
            .scale (scale_q[2*i +: 2]),
            .base  (base_q[ADDR_W*i +: ADDR_W]),
            .hit   (ch_hit[i]),
            .addr  (ch_addr[i])
        );
    end

    always_comb begin
        en_d    = en_q;
        piece_d = piece_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        scale_d = scale_q;
        base_d  = base_q;
        if (frame_start) begin
            en_d    = ch_en;
            piece_d = ch_piece;
            x_d     = ch_x;
            y_d     = ch_y;
            w_d     = ch_w;
            h_d     = ch_h;
            scale_d = ch_scale;
            base_d  = ch_base;
        end

        // scanning high to low leaves the lowest-index hit as winner
        win_hit  = 1'b0;
        win_addr = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_hit[i]) begin
                win_hit  = 1'b1;
                win_addr = ch_addr[i];
            end
        end

        rom_addr_d = (pix_valid && win_hit) ? win_addr : rom_addr_q;
        dl_vld_d   = {dl_vld_q[ROM_LAT-1:0], pix_valid};
        dl_hit_d   = {dl_hit_q[ROM_LAT-1:0], pix_valid && win_hit};
        dl_bg_d    = {dl_bg_q[ROM_LAT-1:0], bg_data};

        out_valid_d = dl_vld_q[ROM_LAT];
        vga_d       = '0;
        if (dl_vld_q[ROM_LAT]) begin
            vga_d = (dl_hit_q[ROM_LAT] && (rom_data != TRANSP_KEY)) ? rom_data : dl_bg_q[ROM_LAT];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= '0;
            piece_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            scale_q     <= '0;
            base_q      <= '0;
            rom_addr_q  <= '0;
            dl_vld_q    <= '0;
            dl_hit_q    <= '0;
            dl_bg_q     <= '0;
            out_valid_q <= 1'b0;
            vga_q       <= '0;
        end else begin
            en_q        <= en_d;
            piece_q     <= piece_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            scale_q     <= scale_d;
            base_q      <= base_d;
            rom_addr_q  <= rom_addr_d;
            dl_vld_q    <= dl_vld_d;
            dl_hit_q    <= dl_hit_d;
            dl_bg_q     <= dl_bg_d;
            out_valid_q <= out_valid_d;
            vga_q       <= vga_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign out_valid = out_valid_q;
    assign vga_data  = vga_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed and random pixel streams checked against an arithmetic model of the compositor.
module tb_sprite_compositor;
    localparam int N_CH    = 4;
    localparam int ADDR_W  = 18;
    localparam int ROM_LAT = 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    frame_start = 1'b0;
    logic                    pix_valid = 1'b0;
    logic [9:0]              col = '0;
    logic [9:0]              row = '0;
    logic [11:0]             bg_data = '0;
    logic [N_CH-1:0]         ch_en = '0;
    logic [2*N_CH-1:0]       ch_piece = '0;
    logic [10*N_CH-1:0]      ch_x = '0;
    logic [10*N_CH-1:0]      ch_y = '0;
    logic [10*N_CH-1:0]      ch_w = '0;
    logic [10*N_CH-1:0]      ch_h = '0;
    logic [2*N_CH-1:0]       ch_scale = '0;
    logic [ADDR_W*N_CH-1:0]  ch_base = '0;
    logic [ADDR_W-1:0]       rom_addr;
    logic [11:0]             rom_data = '0;
    logic                    out_valid;
    logic [11:0]             vga_data;

    int n_assert = 0;
    int n_fail = 0;

    int p_en[N_CH], p_piece[N_CH], p_x[N_CH], p_y[N_CH], p_w[N_CH], p_h[N_CH], p_s[N_CH], p_base[N_CH];
    int a_en[N_CH], a_piece[N_CH], a_x[N_CH], a_y[N_CH], a_w[N_CH], a_h[N_CH], a_s[N_CH], a_base[N_CH];

    // history of expected results: [0] = most recently driven pixel
    bit          h_v[3];
    bit          h_hit[3];
    int          h_addr[3];
    logic [11:0] h_vga[3];

    sprite_compositor #(.N_CH(N_CH), .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT), .TRANSP_KEY(12'h000)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .col(col), .row(row), .bg_data(bg_data),
        .ch_en(ch_en), .ch_piece(ch_piece), .ch_x(ch_x), .ch_y(ch_y), .ch_w(ch_w), .ch_h(ch_h),
        .ch_scale(ch_scale), .ch_base(ch_base),
        .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid), .vga_data(vga_data)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_fn(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        if (a[2:0] == 3'd5) return 12'h000;
        t = (32'(a) * 32'd40503) ^ (32'(a) >> 5);
        if (t[11:0] == 12'h000) return 12'h001;
        return t[11:0];
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model(input int c, input int r, input logic [11:0] bg,
                         output bit hit, output int addr, output logic [11:0] vga);
        hit = 0;
        addr = 0;
        vga = bg;
        for (int i = 0; i < N_CH; i++) begin
            int half, pw, off, sc;
            logic [11:0] tx;
            if (hit || a_en[i] == 0 || a_w[i] == 0 || a_h[i] == 0) continue;
            sc   = 1 << a_s[i];
            half = a_w[i] / 2;
            pw   = (a_piece[i] == 1) ? half : (a_piece[i] == 2) ? a_w[i] - half : a_w[i];
            off  = (a_piece[i] == 2) ? half : 0;
            if (c >= a_x[i] && c < a_x[i] + pw * sc && r >= a_y[i] && r < a_y[i] + a_h[i] * sc) begin
                hit  = 1;
                addr = (a_base[i] + ((r - a_y[i]) / sc) * a_w[i] + (c - a_x[i]) / sc + off) % (1 << ADDR_W);
                tx   = rom_fn(addr[ADDR_W-1:0]);
                vga  = (tx == 12'h000) ? bg : tx;
            end
        end
    endtask

    task automatic set_ch(input int i, input int en, input int piece, input int x, input int y,
                          input int w, input int h, input int s, input int base);
        p_en[i] = en; p_piece[i] = piece; p_x[i] = x; p_y[i] = y;
        p_w[i] = w; p_h[i] = h; p_s[i] = s; p_base[i] = base;
        ch_en[i]                     = (en != 0);
        ch_piece[2*i +: 2]           = 2'(piece);
        ch_x[10*i +: 10]             = 10'(x);
        ch_y[10*i +: 10]             = 10'(y);
        ch_w[10*i +: 10]             = 10'(w);
        ch_h[10*i +: 10]             = 10'(h);
        ch_scale[2*i +: 2]           = 2'(s);
        ch_base[ADDR_W*i +: ADDR_W]  = ADDR_W'(base);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N_CH; i++) set_ch(i, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // one clock: check outputs due now, then drive the next pixel and predict it
    task automatic step(input bit v, input int c, input int r, input bit fs, input bit rs);
        bit          hit;
        int          addr;
        logic [11:0] vga;
        logic [11:0] bg;
        @(negedge clk);
        if (h_v[0] && h_hit[0]) chk("rom_addr", 32'(rom_addr), 32'(h_addr[0]));
        chk("out_valid", 32'(out_valid), 32'(h_v[2]));
        chk("vga_data", 32'(vga_data), h_v[2] ? 32'(h_vga[2]) : 32'd0);
        for (int k = 2; k > 0; k--) begin
            h_v[k] = h_v[k-1]; h_hit[k] = h_hit[k-1]; h_addr[k] = h_addr[k-1]; h_vga[k] = h_vga[k-1];
        end
        bg          = 12'($urandom);
        pix_valid   = v;
        col         = 10'(c);
        row         = 10'(r);
        bg_data     = bg;
        frame_start = fs;
        rst         = rs;
        model(c, r, bg, hit, addr, vga);
        h_v[0] = v; h_hit[0] = v && hit; h_addr[0] = addr; h_vga[0] = vga;
        if (rs) begin
            for (int k = 0; k < 3; k++) begin h_v[k] = 0; h_hit[k] = 0; end
            for (int i = 0; i < N_CH; i++) a_en[i] = 0;
        end else if (fs) begin
            a_en = p_en; a_piece = p_piece; a_x = p_x; a_y = p_y;
            a_w = p_w; a_h = p_h; a_s = p_s; a_base = p_base;
        end
    endtask

    task automatic px(input int c, input int r);
        step(1, c, r, 0, 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic frame();
        step(0, 0, 0, 1, 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin h_v[k] = 0; h_hit[k] = 0; h_addr[k] = 0; h_vga[k] = '0; end
        clear_all();
        for (int i = 0; i < N_CH; i++) a_en[i] = 0;
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);

        // single whole sprite, plus rom_addr hold on invalid pixels
        set_ch(0, 1, 0, 100, 50, 32, 32, 0, 0);
        frame();
        px(105, 52);
        step(0, 131, 81, 0, 0);
        step(0, 131, 81, 0, 0);
        chk("hold_rom_addr", 32'(rom_addr), 32'd69);
        px(99, 52); px(131, 81); px(132, 52); px(100, 49); idle(); idle();

        // left/right halves of an odd-width image
        clear_all();
        set_ch(0, 1, 1, 200, 0, 33, 4, 0, 0);
        set_ch(1, 1, 2, 200, 0, 33, 4, 0, 0);
        frame();
        px(200, 0); px(215, 0); px(216, 0); px(216, 3); px(217, 1); px(232, 0); px(233, 0);

        // transparent winner hides a lower-priority overlap
        clear_all();
        set_ch(0, 1, 0, 0, 0, 8, 8, 0, 0);
        set_ch(2, 1, 0, 0, 0, 16, 8, 0, 100);
        frame();
        px(5, 0); px(6, 0); px(13, 0); px(5, 1);

        // scaled sprite
        clear_all();
        set_ch(1, 1, 0, 0, 0, 8, 8, 2, 1000);
        frame();
        px(13, 6); px(32, 0); px(31, 31); px(0, 32);

        // right-edge clip and address wrap
        clear_all();
        set_ch(3, 1, 0, 1000, 10, 64, 4, 0, 5);
        set_ch(0, 1, 3, 0, 0, 16, 16, 3, 262140);
        frame();
        px(1023, 10); px(999, 10); px(0, 10); px(1000, 13); px(1000, 14); px(127, 127); px(128, 0);

        // config change only takes effect after frame_start
        clear_all();
        set_ch(0, 1, 0, 100, 50, 32, 32, 0, 0);
        frame();
        px(105, 52);
        set_ch(0, 1, 0, 300, 50, 32, 32, 0, 0);
        px(105, 52); px(305, 52);
        step(1, 305, 52, 1, 0);
        px(305, 52); px(105, 52);

        // reset during active pixels
        px(306, 53);
        step(1, 307, 52, 0, 1);
        step(1, 308, 52, 0, 1);
        px(309, 52); px(310, 52); px(311, 53);
        frame();
        px(310, 52); px(311, 53); idle(); idle();

        // random configurations and pixel streams
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < N_CH; i++) begin
                set_ch(i, ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 3),
                       $urandom_range(0, 250), $urandom_range(0, 150), $urandom_range(0, 48),
                       $urandom_range(0, 40), $urandom_range(0, 3), $urandom_range(0, (1 << ADDR_W) - 1));
            end
            frame();
            for (int n = 0; n < 60; n++) begin
                step($urandom_range(0, 9) < 8, $urandom_range(0, 300), $urandom_range(0, 200), 0, 0);
            end
        end
        repeat (4) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
